// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/DMA arbiter for a shared single-port memory with fixed-length accesses
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        dma_req,
  input  logic        cpu_we,
  input  logic        dma_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] dma_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] dma_wdata,
  output logic [31:0] cpu_rdata,
  output logic [31:0] dma_rdata,
  output logic        cpu_ready,
  output logic        dma_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [1:0]  grant,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, DONE = 2'b10} state_t;
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_owner, r_last, r_we, r_mem_re, r_mem_we, r_cpu_ready, r_dma_ready;
  logic [31:0] r_addr, r_wdata, r_cpu_rdata, r_dma_rdata;
  logic [1:0]  r_grant;
  logic        w_pick_dma, w_we;
  // r_last/r_owner: 0 = CPU, 1 = DMA; on a tie the one not served last wins
  assign w_pick_dma = dma_req & (~cpu_req | ~r_last);
  assign w_we       = w_pick_dma ? dma_we : cpu_we;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_grant     <= 2'b00;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_dma_ready <= 1'b0;
    end else begin
      r_cpu_ready <= 1'b0;
      r_dma_ready <= 1'b0;
      case (r_state)
        IDLE: if (cpu_req | dma_req) begin
          r_state  <= ACCESS;
          r_cnt    <= '0;
          r_owner  <= w_pick_dma;
          r_grant  <= w_pick_dma ? 2'b10 : 2'b01;
          r_addr   <= w_pick_dma ? dma_addr : cpu_addr;
          r_wdata  <= w_pick_dma ? dma_wdata : cpu_wdata;
          r_we     <= w_we;
          r_mem_re <= ~w_we;
          r_mem_we <= w_we;
        end
        ACCESS: if (r_cnt == 4'(WAIT_CYCLES - 1)) begin
          r_state     <= DONE;
          r_mem_re    <= 1'b0;
          r_mem_we    <= 1'b0;
          r_cpu_ready <= ~r_owner;
          r_dma_ready <= r_owner;
          if (!r_we && !r_owner) r_cpu_rdata <= mem_rdata;
          if (!r_we && r_owner) r_dma_rdata <= mem_rdata;
        end else r_cnt <= r_cnt + 4'd1;
        DONE: begin
          r_state <= IDLE;
          r_grant <= 2'b00;
          r_last  <= r_owner;
        end
        default: begin
          r_state  <= IDLE;
          r_grant  <= 2'b00;
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;
  assign cpu_ready = r_cpu_ready;
  assign dma_ready = r_dma_ready;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign grant     = r_grant;
  assign state     = r_state;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, timing, latching and reset of mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req = 0, dma_req = 0, cpu_we = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, dma_addr = 0, cpu_wdata = 0, dma_wdata = 0, mem_val = 0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic cpu_ready, dma_ready, mem_re, mem_we;
  logic [1:0] grant, state;
  logic req1 = 0, req15 = 0, nodma = 0;
  logic [31:0] a_crd, a_drd, a_ma, a_mw, b_crd, b_drd, b_ma, b_mw;
  logic a_cr, a_dr, a_re, a_we, b_cr, b_dr, b_re, b_we;
  logic [1:0] a_g, a_s, b_g, b_s;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .dma_req(dma_req), .cpu_we(cpu_we), .dma_we(dma_we),
    .cpu_addr(cpu_addr), .dma_addr(dma_addr), .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
    .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata), .cpu_ready(cpu_ready), .dma_ready(dma_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_val), .mem_re(mem_re),
    .mem_we(mem_we), .grant(grant), .state(state));

  mem_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .cpu_req(req1), .dma_req(nodma), .cpu_we(nodma), .dma_we(nodma),
    .cpu_addr(cpu_addr), .dma_addr(dma_addr), .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
    .cpu_rdata(a_crd), .dma_rdata(a_drd), .cpu_ready(a_cr), .dma_ready(a_dr),
    .mem_addr(a_ma), .mem_wdata(a_mw), .mem_rdata(mem_val), .mem_re(a_re),
    .mem_we(a_we), .grant(a_g), .state(a_s));

  mem_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst(rst), .cpu_req(req15), .dma_req(nodma), .cpu_we(nodma), .dma_we(nodma),
    .cpu_addr(cpu_addr), .dma_addr(dma_addr), .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
    .cpu_rdata(b_crd), .dma_rdata(b_drd), .cpu_ready(b_cr), .dma_ready(b_dr),
    .mem_addr(b_ma), .mem_wdata(b_mw), .mem_rdata(mem_val), .mem_re(b_re),
    .mem_we(b_we), .grant(b_g), .state(b_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({state, grant, mem_re, mem_we, cpu_ready, dma_ready} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl got state=%b grant=%b re=%b we=%b rdy=%b%b exp all 0",
               state, grant, mem_re, mem_we, cpu_ready, dma_ready);
    end
    n_checks++;
    if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data got addr=%h wdata=%h crd=%h drd=%h exp 0",
               mem_addr, mem_wdata, cpu_rdata, dma_rdata);
    end
  endtask

  task automatic test_cpu_read();
    int re_n = 0, rdy_n = 0, rdy_at = 0;
    logic addr_ok = 1'b1;
    mem_val = 32'hDEADBEEF;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (mem_re) begin
        re_n++;
        if (mem_addr !== 32'h10 || grant !== 2'b01) addr_ok = 1'b0;
      end
      if (cpu_ready) begin
        rdy_n++;
        rdy_at = i;
        cpu_req = 0;
      end
    end
    n_checks++;
    if (re_n != 2) begin n_fail++; $display("FAIL read_re_cycles got %0d exp 2", re_n); end
    n_checks++;
    if (rdy_n != 1 || rdy_at != 3) begin
      n_fail++;
      $display("FAIL read_ready got count=%0d at=%0d exp count=1 at=3", rdy_n, rdy_at);
    end
    n_checks++;
    if (!addr_ok) begin n_fail++; $display("FAIL read_addr_grant got bad addr/grant exp 10/01"); end
    n_checks++;
    if (cpu_rdata !== 32'hDEADBEEF || dma_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL read_rdata got crd=%h drd=%h exp deadbeef/0", cpu_rdata, dma_rdata);
    end
  endtask

  task automatic test_tie();
    int c_n = 0, d_n = 0, overlap = 0, dma_early = 0;
    logic [1:0] g1 = 2'b00, g2 = 2'b00;
    do_reset();
    mem_val = 32'hA5A5A5A5;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h18;
    dma_req = 1; dma_we = 0; dma_addr = 32'h30;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (grant != 2'b00 && g1 == 2'b00) g1 = grant;
      else if (grant != 2'b00 && grant != g1 && g2 == 2'b00) g2 = grant;
      if (cpu_ready && dma_ready) overlap++;
      if (dma_ready && c_n == 0) dma_early++;
      if (cpu_ready) begin c_n++; cpu_req = 0; end
      if (dma_ready) begin d_n++; dma_req = 0; end
    end
    n_checks++;
    if (g1 !== 2'b01 || g2 !== 2'b10) begin
      n_fail++;
      $display("FAIL tie_grant_order got %b then %b exp 01 then 10", g1, g2);
    end
    n_checks++;
    if (c_n != 1 || d_n != 1 || overlap != 0 || dma_early != 0) begin
      n_fail++;
      $display("FAIL tie_ready got cpu=%0d dma=%0d overlap=%0d early=%0d exp 1 1 0 0",
               c_n, d_n, overlap, dma_early);
    end
    n_checks++;
    if (dma_rdata !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL tie_dma_rdata got %h exp a5a5a5a5", dma_rdata);
    end
  endtask

  task automatic test_dma_write();
    int we_ok = 0, re_n = 0, rdy_n = 0;
    mem_val = 32'h0BADF00D;
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h12345678;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) begin dma_addr = 32'h99; dma_wdata = 32'h0; dma_we = 0; end
      if (mem_we && mem_addr === 32'h20 && mem_wdata === 32'h12345678) we_ok++;
      if (mem_re) re_n++;
      if (dma_ready) begin rdy_n++; dma_req = 0; end
    end
    n_checks++;
    if (we_ok != 2 || re_n != 0) begin
      n_fail++;
      $display("FAIL write_strobes got we_ok=%0d re=%0d exp 2 0", we_ok, re_n);
    end
    n_checks++;
    if (rdy_n != 1) begin n_fail++; $display("FAIL write_ready got %0d exp 1", rdy_n); end
    n_checks++;
    if (cpu_rdata !== 32'hA5A5A5A5 || dma_rdata !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL write_rdata got crd=%h drd=%h exp a5a5a5a5 both", cpu_rdata, dma_rdata);
    end
    n_checks++;
    if (state !== 2'b00 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL write_hold got state=%b addr=%h wdata=%h exp 00/20/12345678",
               state, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_drop();
    int rdy_n = 0;
    mem_val = 32'h55AA55AA;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    tick();
    cpu_req = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cpu_ready) rdy_n++;
    end
    n_checks++;
    if (rdy_n != 1 || cpu_rdata !== 32'h55AA55AA) begin
      n_fail++;
      $display("FAIL drop_complete got ready=%0d rdata=%h exp 1/55aa55aa", rdy_n, cpu_rdata);
    end
    n_checks++;
    if (state !== 2'b00 || grant !== 2'b00) begin
      n_fail++;
      $display("FAIL drop_idle got state=%b grant=%b exp 00/00", state, grant);
    end
  endtask

  task automatic test_reset_abort();
    int rdy_n = 0;
    mem_val = 32'h77777777;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h50;
    tick();
    tick();
    n_checks++;
    if (state !== 2'b01 || mem_re !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre got state=%b re=%b exp 01/1", state, mem_re);
    end
    rst = 1; cpu_req = 0;
    tick();
    rst = 0;
    n_checks++;
    if (state !== 2'b00 || mem_re !== 1'b0 || mem_we !== 1'b0 || cpu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_state got state=%b re=%b we=%b rdata=%h exp 00/0/0/0",
               state, mem_re, mem_we, cpu_rdata);
    end
    if (cpu_ready) rdy_n++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_ready || dma_ready) rdy_n++;
    end
    n_checks++;
    if (rdy_n != 0 || cpu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_noready got ready=%0d rdata=%h exp 0/0", rdy_n, cpu_rdata);
    end
  endtask

  task automatic test_wait_cycles();
    int a_last = -1, a_prev = -1, a_n = 0, b_last = -1, b_prev = -1, b_n = 0;
    req1 = 1; req15 = 1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (a_cr) begin a_n++; a_prev = a_last; a_last = i; end
      if (b_cr) begin b_n++; b_prev = b_last; b_last = i; end
    end
    req1 = 0; req15 = 0;
    n_checks++;
    if (a_n < 2 || a_last - a_prev != 3) begin
      n_fail++;
      $display("FAIL wait1_period got count=%0d period=%0d exp period 3", a_n, a_last - a_prev);
    end
    n_checks++;
    if (b_n < 2 || b_last - b_prev != 17) begin
      n_fail++;
      $display("FAIL wait15_period got count=%0d period=%0d exp period 17", b_n, b_last - b_prev);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_tie();
    test_dma_write();
    test_drop();
    test_reset_abort();
    test_wait_cycles();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
